// File: rtl/execute.sv
// Execute stage: E pipeline register, ALU, and a sequential signed mult/div unit with HI/LO.
// Latency: ALU and forwarding are combinational from the E register; mult/div take 32 RUN cycles after the start edge.
// Backpressure: BusyE holds the E register while the MD unit runs and the E instruction reads HI/LO or issues an MD op.
//
// Ports:
//   clk, rst (async active-low)        -- clock and reset
//   *D decode-side controls and data   -- captured into the E register when BusyE=0
//   FlushE                             -- clears the control fields of the E register (bubble)
//   jumpE/RegWriteE/MemWriteE/...      -- memory-side outputs from the registered instruction
//   ALUMultOutE                        -- ALU result, or LO/HI when the instruction is mflo/mfhi
//   BusyE                              -- stall request to the hazard unit
module execute (
    input  logic        clk,
    input  logic        rst,
    input  logic        RegWriteD,
    input  logic        MemWriteD,
    input  logic        jumpD,
    input  logic        ALUSrcD,
    input  logic        RegDstD,
    input  logic [2:0]  MemtoRegD,
    input  logic [2:0]  ALUControlD,
    input  logic [1:0]  MDOpD,
    input  logic [1:0]  MDReadD,
    input  logic [31:0] RD1D,
    input  logic [31:0] RD2D,
    input  logic [31:0] SignImmD,
    input  logic [31:0] PCPlus4D,
    input  logic [4:0]  RtD,
    input  logic [4:0]  RdD,
    input  logic        FlushE,
    output logic        jumpE,
    output logic        RegWriteE,
    output logic        MemWriteE,
    output logic [2:0]  MemtoRegE,
    output logic [4:0]  WriteRegE,
    output logic [31:0] ALUMultOutE,
    output logic [31:0] WriteDataE,
    output logic [31:0] PCPlus4E,
    output logic        BusyE
);

    typedef struct packed {
        logic        reg_write;
        logic        mem_write;
        logic        jump;
        logic        alu_src;
        logic        reg_dst;
        logic [2:0]  mem_to_reg;
        logic [2:0]  alu_ctrl;
        logic [1:0]  md_op;
        logic [1:0]  md_read;
        logic [31:0] rd1;
        logic [31:0] rd2;
        logic [31:0] imm;
        logic [31:0] pc4;
        logic [4:0]  rt;
        logic [4:0]  rd;
    } ereg_t;

    typedef enum logic {S_IDLE, S_RUN} md_state_t;

    ereg_t       r_e;
    ereg_t       w_d;
    md_state_t   r_state;
    logic [4:0]  r_count;
    logic [31:0] r_hi;
    logic [31:0] r_lo;
    logic [31:0] r_op;      // multiplicand (mult) or divisor magnitude (div)
    logic [31:0] r_rem;     // partial remainder (div)
    logic [63:0] r_prod;    // product (mult); low half holds dividend/quotient (div)
    logic        r_is_div;
    logic        r_neg_q;   // product / quotient must be negated
    logic        r_neg_r;   // remainder takes dividend sign
    logic        r_dz;      // divide by zero

    logic [31:0] w_srcb;
    logic [31:0] w_alu;
    logic        w_md_start;
    logic [31:0] w_abs1;
    logic [31:0] w_abs2;
    logic [32:0] w_madd;
    logic [63:0] w_prod_mul;
    logic [32:0] w_shift;
    logic        w_ge;
    logic [31:0] w_diff;
    logic [31:0] w_rem_div;
    logic [31:0] w_q_div;
    logic [63:0] w_prod_fin;
    logic [31:0] w_quot_fin;
    logic [31:0] w_rem_fin;

    // ---------------- E pipeline register ----------------
    always_comb begin
        w_d            = '0;
        w_d.reg_write  = RegWriteD;
        w_d.mem_write  = MemWriteD;
        w_d.jump       = jumpD;
        w_d.alu_src    = ALUSrcD;
        w_d.reg_dst    = RegDstD;
        w_d.mem_to_reg = MemtoRegD;
        w_d.alu_ctrl   = ALUControlD;
        w_d.md_op      = MDOpD;
        w_d.md_read    = MDReadD;
        w_d.rd1        = RD1D;
        w_d.rd2        = RD2D;
        w_d.imm        = SignImmD;
        w_d.pc4        = PCPlus4D;
        w_d.rt         = RtD;
        w_d.rd         = RdD;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_e <= '0;
        end else begin
            if (!BusyE) begin
                r_e <= w_d;
            end
            // Flush overrides a stall: the held instruction becomes a bubble.
            if (FlushE) begin
                r_e.reg_write  <= 1'b0;
                r_e.mem_write  <= 1'b0;
                r_e.jump       <= 1'b0;
                r_e.mem_to_reg <= 3'b000;
                r_e.md_op      <= 2'b00;
                r_e.md_read    <= 2'b00;
            end
        end
    end

    // ---------------- ALU ----------------
    assign w_srcb = r_e.alu_src ? r_e.imm : r_e.rd2;

    always_comb begin
        w_alu = '0;
        case (r_e.alu_ctrl)
            3'b000:  w_alu = r_e.rd1 & w_srcb;
            3'b001:  w_alu = r_e.rd1 | w_srcb;
            3'b010:  w_alu = r_e.rd1 + w_srcb;
            3'b011:  w_alu = r_e.rd1 ^ w_srcb;
            3'b100:  w_alu = ~(r_e.rd1 | w_srcb);
            3'b101:  w_alu = {31'b0, (r_e.rd1 < w_srcb)};
            3'b110:  w_alu = r_e.rd1 - w_srcb;
            default: w_alu = {31'b0, ($signed(r_e.rd1) < $signed(w_srcb))};
        endcase
    end

    // ---------------- MD datapath ----------------
    assign w_md_start = (r_e.md_op == 2'b01) || (r_e.md_op == 2'b10);
    assign w_abs1     = r_e.rd1[31] ? (32'd0 - r_e.rd1) : r_e.rd1;
    assign w_abs2     = r_e.rd2[31] ? (32'd0 - r_e.rd2) : r_e.rd2;

    // Shift-add multiply: add multiplicand into the upper half when the LSB is set, then shift right.
    assign w_madd     = {1'b0, r_prod[63:32]} + (r_prod[0] ? {1'b0, r_op} : 33'd0);
    assign w_prod_mul = {w_madd, r_prod[31:1]};

    // Restoring divide: shift next dividend bit into the remainder, subtract divisor if it fits.
    assign w_shift    = {r_rem, r_prod[31]};
    assign w_ge       = (w_shift >= {1'b0, r_op});
    assign w_diff     = w_shift[31:0] - r_op;
    assign w_rem_div  = w_ge ? w_diff : w_shift[31:0];
    assign w_q_div    = {r_prod[30:0], w_ge};

    // Sign fix-up on the final step. With a zero divisor every step "fits", so the
    // remainder ends as |dividend| and the sign fix-up restores the dividend itself.
    assign w_prod_fin = r_neg_q ? (64'd0 - w_prod_mul) : w_prod_mul;
    assign w_quot_fin = r_dz ? 32'hFFFF_FFFF : (r_neg_q ? (32'd0 - w_q_div) : w_q_div);
    assign w_rem_fin  = r_neg_r ? (32'd0 - w_rem_div) : w_rem_div;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state  <= S_IDLE;
            r_count  <= 5'd0;
            r_hi     <= 32'd0;
            r_lo     <= 32'd0;
            r_op     <= 32'd0;
            r_rem    <= 32'd0;
            r_prod   <= 64'd0;
            r_is_div <= 1'b0;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
            r_dz     <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_md_start) begin
                        r_state  <= S_RUN;
                        r_count  <= 5'd0;
                        r_is_div <= (r_e.md_op == 2'b10);
                        r_neg_q  <= r_e.rd1[31] ^ r_e.rd2[31];
                        r_neg_r  <= r_e.rd1[31];
                        r_dz     <= (r_e.rd2 == 32'd0);
                        r_rem    <= 32'd0;
                        if (r_e.md_op == 2'b10) begin
                            r_op   <= w_abs2;
                            r_prod <= {32'd0, w_abs1};
                        end else begin
                            r_op   <= w_abs1;
                            r_prod <= {32'd0, w_abs2};
                        end
                    end
                end
                default: begin
                    r_count <= r_count + 5'd1;
                    if (r_is_div) begin
                        r_rem  <= w_rem_div;
                        r_prod <= {32'd0, w_q_div};
                    end else begin
                        r_prod <= w_prod_mul;
                    end
                    if (r_count == 5'd31) begin
                        r_state <= S_IDLE;
                        if (r_is_div) begin
                            r_hi <= w_rem_fin;
                            r_lo <= w_quot_fin;
                        end else begin
                            r_hi <= w_prod_fin[63:32];
                            r_lo <= w_prod_fin[31:0];
                        end
                    end
                end
            endcase
        end
    end

    // ---------------- outputs ----------------
    assign BusyE       = (r_state == S_RUN) && ((r_e.md_read != 2'b00) || w_md_start);
    assign jumpE       = r_e.jump & ~BusyE;
    assign RegWriteE   = r_e.reg_write & ~BusyE;
    assign MemWriteE   = r_e.mem_write & ~BusyE;
    assign MemtoRegE   = r_e.mem_to_reg;
    assign WriteRegE   = r_e.reg_dst ? r_e.rd : r_e.rt;
    assign WriteDataE  = r_e.rd2;
    assign PCPlus4E    = r_e.pc4;
    assign ALUMultOutE = (r_e.md_read == 2'b01) ? r_lo :
                         (r_e.md_read == 2'b10) ? r_hi : w_alu;

endmodule

// File: tb/tb_execute.sv
module tb_execute;

    typedef struct packed {
        logic        rw;
        logic        mw;
        logic        j;
        logic        alusrc;
        logic        regdst;
        logic [2:0]  m2r;
        logic [2:0]  aluc;
        logic [1:0]  mdop;
        logic [1:0]  mdread;
        logic [31:0] rd1;
        logic [31:0] rd2;
        logic [31:0] imm;
        logic [31:0] pc4;
        logic [4:0]  rt;
        logic [4:0]  rd;
    } instr_t;

    logic        clk;
    logic        rst;
    logic        flush;
    instr_t      din;

    logic        jumpE, RegWriteE, MemWriteE, BusyE;
    logic [2:0]  MemtoRegE;
    logic [4:0]  WriteRegE;
    logic [31:0] ALUMultOutE, WriteDataE, PCPlus4E;

    int n_chk  = 0;
    int n_pass = 0;

    // Reference model state: instruction in E, architectural HI/LO,
    // cycles of MD work still outstanding, and the result it will deliver.
    instr_t      me;
    logic [31:0] m_hi, m_lo, p_hi, p_lo;
    int          m_left;

    execute dut (
        .clk(clk), .rst(rst),
        .RegWriteD(din.rw), .MemWriteD(din.mw), .jumpD(din.j),
        .ALUSrcD(din.alusrc), .RegDstD(din.regdst),
        .MemtoRegD(din.m2r), .ALUControlD(din.aluc),
        .MDOpD(din.mdop), .MDReadD(din.mdread),
        .RD1D(din.rd1), .RD2D(din.rd2), .SignImmD(din.imm), .PCPlus4D(din.pc4),
        .RtD(din.rt), .RdD(din.rd), .FlushE(flush),
        .jumpE(jumpE), .RegWriteE(RegWriteE), .MemWriteE(MemWriteE),
        .MemtoRegE(MemtoRegE), .WriteRegE(WriteRegE),
        .ALUMultOutE(ALUMultOutE), .WriteDataE(WriteDataE), .PCPlus4E(PCPlus4E),
        .BusyE(BusyE)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s t=%0t got %h want %h", name, $time, act, exp);
    endtask

    function automatic instr_t mk(input logic [2:0] aluc, input logic [1:0] mdop,
                                  input logic [1:0] mdread, input logic [31:0] a,
                                  input logic [31:0] b);
        instr_t i;
        i        = '0;
        i.aluc   = aluc;
        i.mdop   = mdop;
        i.mdread = mdread;
        i.rd1    = a;
        i.rd2    = b;
        i.rw     = (mdop == 2'b00);
        i.regdst = 1'b1;
        i.rt     = 5'd3;
        i.rd     = 5'd9;
        i.pc4    = a + 32'd4;
        i.imm    = 32'h0000_1234;
        return i;
    endfunction

    function automatic logic [31:0] alu_ref(input logic [2:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
        case (op)
            3'd0:    return a & b;
            3'd1:    return a | b;
            3'd2:    return a + b;
            3'd3:    return a ^ b;
            3'd4:    return ~(a | b);
            3'd5:    return (a < b) ? 32'd1 : 32'd0;
            3'd6:    return a - b;
            default: return (int'(a) < int'(b)) ? 32'd1 : 32'd0;
        endcase
    endfunction

    function automatic void md_ref(input logic [1:0] op, input logic [31:0] a,
                                   input logic [31:0] b, output logic [31:0] hi,
                                   output logic [31:0] lo);
        longint p;
        if (op == 2'b01) begin
            p  = longint'($signed(a)) * longint'($signed(b));
            hi = p[63:32];
            lo = p[31:0];
        end else if (b == 32'd0) begin
            lo = 32'hFFFF_FFFF;
            hi = a;
        end else begin
            lo = int'(a) / int'(b);
            hi = int'(a) % int'(b);
        end
    endfunction

    function automatic logic busy_ref(input instr_t e, input int left);
        return (left > 0) && (e.mdread != 2'b00 || e.mdop == 2'b01 || e.mdop == 2'b10);
    endfunction

    // Reference model update.
    always @(posedge clk or negedge rst) begin : model
        instr_t      ne;
        logic [31:0] nhi, nlo, nph, npl;
        int          nl;
        logic        b;
        if (!rst) begin
            me     <= '0;
            m_hi   <= '0;
            m_lo   <= '0;
            p_hi   <= '0;
            p_lo   <= '0;
            m_left <= 0;
        end else begin
            b   = busy_ref(me, m_left);
            ne  = me;
            nl  = m_left;
            nhi = m_hi;
            nlo = m_lo;
            nph = p_hi;
            npl = p_lo;
            if (m_left > 0) begin
                nl = m_left - 1;
                if (nl == 0) begin
                    nhi = p_hi;
                    nlo = p_lo;
                end
            end else if (me.mdop == 2'b01 || me.mdop == 2'b10) begin
                md_ref(me.mdop, me.rd1, me.rd2, nph, npl);
                nl = 32;
            end
            if (!b) ne = din;
            if (flush) begin
                ne.rw = 1'b0; ne.mw = 1'b0; ne.j = 1'b0;
                ne.m2r = 3'b000; ne.mdop = 2'b00; ne.mdread = 2'b00;
            end
            me     <= ne;
            m_hi   <= nhi;
            m_lo   <= nlo;
            p_hi   <= nph;
            p_lo   <= npl;
            m_left <= nl;
        end
    end

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin : compare
        logic        eb;
        logic [31:0] sb, res;
        eb  = busy_ref(me, m_left);
        sb  = me.alusrc ? me.imm : me.rd2;
        res = (me.mdread == 2'b01) ? m_lo : (me.mdread == 2'b10) ? m_hi : alu_ref(me.aluc, me.rd1, sb);
        chk("BusyE",       32'(BusyE),     32'(eb));
        chk("jumpE",       32'(jumpE),     32'(me.j & ~eb));
        chk("RegWriteE",   32'(RegWriteE), 32'(me.rw & ~eb));
        chk("MemWriteE",   32'(MemWriteE), 32'(me.mw & ~eb));
        chk("MemtoRegE",   32'(MemtoRegE), 32'(me.m2r));
        chk("WriteRegE",   32'(WriteRegE), 32'(me.regdst ? me.rd : me.rt));
        chk("ALUMultOutE", ALUMultOutE,    res);
        chk("WriteDataE",  WriteDataE,     me.rd2);
        chk("PCPlus4E",    PCPlus4E,       me.pc4);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input instr_t d);
        din = d;
        tick();
    endtask

    task automatic wait_free();
        int n;
        n = 0;
        while (BusyE === 1'b1 && n < 40) begin
            tick();
            n++;
        end
        chk("wait_bound", 32'(n < 40), 32'd1);
    endtask

    localparam logic [1:0] NONE = 2'b00, MULT = 2'b01, DIV = 2'b10;
    localparam logic [1:0] RLO = 2'b01, RHI = 2'b10;

    initial begin
        instr_t i;
        rst   = 1'b0;
        flush = 1'b0;
        din   = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", 32'(BusyE), 32'd0);
        chk("rst_out",  ALUMultOutE, 32'd0);
        chk("rst_rw",   32'(RegWriteE), 32'd0);
        rst = 1'b1;

        // ALU corner cases
        issue(mk(3'b010, NONE, 2'b00, 32'h7FFF_FFFF, 32'h1));
        chk("add_wrap", ALUMultOutE, 32'h8000_0000);
        issue(mk(3'b111, NONE, 2'b00, 32'hFFFF_FFFF, 32'h1));
        chk("slt_signed", ALUMultOutE, 32'h1);
        issue(mk(3'b101, NONE, 2'b00, 32'hFFFF_FFFF, 32'h1));
        chk("sltu", ALUMultOutE, 32'h0);
        issue(mk(3'b110, NONE, 2'b00, 32'h5, 32'h7));
        chk("sub_wrap", ALUMultOutE, 32'hFFFF_FFFE);
        i = mk(3'b000, NONE, 2'b00, 32'hF0F0_F0F0, 32'h0FF0_0FF0);
        i.alusrc = 1'b1; i.imm = 32'h0000_FFFF; i.regdst = 1'b0;
        i.j = 1'b1; i.mw = 1'b1; i.m2r = 3'b101;
        issue(i);
        chk("and_imm", ALUMultOutE, 32'h0000_F0F0);
        chk("rt_sel",  32'(WriteRegE), 32'd3);
        chk("jump_pass", 32'(jumpE), 32'd1);
        for (int k = 0; k < 8; k++) issue(mk(3'(k), NONE, 2'b00, 32'h8000_0005, 32'h0000_0007));

        // mult -3*5, mflo stalls 32 cycles
        issue(mk(3'b010, MULT, 2'b00, 32'hFFFF_FFFD, 32'h5));
        chk("mult_T_busy", 32'(BusyE), 32'd0);
        i = mk(3'b010, NONE, RLO, 32'h0, 32'h0);
        i.j = 1'b1; i.mw = 1'b1;
        issue(i);
        chk("stall_T1_busy", 32'(BusyE), 32'd1);
        chk("stall_rw",      32'(RegWriteE), 32'd0);
        chk("stall_jump",    32'(jumpE), 32'd0);
        repeat (31) tick();
        chk("stall_T32_busy", 32'(BusyE), 32'd1);
        tick();
        chk("T33_busy", 32'(BusyE), 32'd0);
        chk("mflo_mult", ALUMultOutE, 32'hFFFF_FFF1);
        chk("T33_rw",    32'(RegWriteE), 32'd1);
        issue(mk(3'b010, NONE, RHI, 32'h0, 32'h0));
        chk("mfhi_mult", ALUMultOutE, 32'hFFFF_FFFF);

        // div 7 / -2 and div by zero
        issue(mk(3'b010, DIV, 2'b00, 32'h7, 32'hFFFF_FFFE));
        issue(mk(3'b010, NONE, RLO, 32'h0, 32'h0));
        wait_free();
        chk("div_lo", ALUMultOutE, 32'hFFFF_FFFD);
        issue(mk(3'b010, NONE, RHI, 32'h0, 32'h0));
        chk("div_hi", ALUMultOutE, 32'h0000_0001);
        issue(mk(3'b010, DIV, 2'b00, 32'h7, 32'h0));
        issue(mk(3'b010, NONE, RLO, 32'h0, 32'h0));
        wait_free();
        chk("div0_lo", ALUMultOutE, 32'hFFFF_FFFF);
        issue(mk(3'b010, NONE, RHI, 32'h0, 32'h0));
        chk("div0_hi", ALUMultOutE, 32'h0000_0007);

        // independent ALU work while the MD unit runs
        issue(mk(3'b010, MULT, 2'b00, 32'h1234_5678, 32'h0000_0100));
        issue(mk(3'b010, NONE, 2'b00, 32'd100, 32'd23));
        chk("indep_busy", 32'(BusyE), 32'd0);
        chk("indep_rw",   32'(RegWriteE), 32'd1);
        chk("indep_add",  ALUMultOutE, 32'd123);
        issue(mk(3'b110, NONE, 2'b00, 32'd10, 32'd3));
        chk("indep_sub",  ALUMultOutE, 32'd7);
        issue(mk(3'b010, NONE, RHI, 32'h0, 32'h0));
        wait_free();
        chk("mfhi_big", ALUMultOutE, 32'h0000_0012);
        issue(mk(3'b010, NONE, RLO, 32'h0, 32'h0));
        chk("mflo_big", ALUMultOutE, 32'h3456_7800);

        // reset abort at count 10
        issue(mk(3'b010, MULT, 2'b00, 32'hFFFF_FFFF, 32'h2));
        issue(mk(3'b010, NONE, RLO, 32'h0, 32'h0));
        repeat (10) tick();
        #2;
        rst = 1'b0;
        #1;
        chk("abort_busy", 32'(BusyE), 32'd0);
        chk("abort_out",  ALUMultOutE, 32'd0);
        din = mk(3'b010, NONE, RHI, 32'h0, 32'h0);
        #4;
        rst = 1'b1;
        tick();
        chk("abort_mfhi", ALUMultOutE, 32'd0);
        chk("abort_idle", 32'(BusyE), 32'd0);
        issue(mk(3'b010, NONE, RLO, 32'h0, 32'h0));
        chk("abort_mflo", ALUMultOutE, 32'd0);

        // flush while stalled on mflo
        issue(mk(3'b010, DIV, 2'b00, 32'hFFFF_FFF9, 32'h2));
        i = mk(3'b010, NONE, RLO, 32'h11, 32'h22);
        i.m2r = 3'b001;
        issue(i);
        chk("pre_flush_busy", 32'(BusyE), 32'd1);
        repeat (3) tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        din = mk(3'b000, NONE, 2'b00, 32'h0, 32'h0);
        chk("flush_rw",   32'(RegWriteE), 32'd0);
        chk("flush_m2r",  32'(MemtoRegE), 32'd0);
        chk("flush_busy", 32'(BusyE), 32'd0);
        chk("flush_alu",  ALUMultOutE, 32'h0000_0033);
        issue(mk(3'b010, NONE, RLO, 32'h0, 32'h0));
        wait_free();
        chk("flush_lo", ALUMultOutE, 32'hFFFF_FFFD);
        issue(mk(3'b010, NONE, RHI, 32'h0, 32'h0));
        chk("flush_hi", ALUMultOutE, 32'hFFFF_FFFF);

        repeat (2) tick();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
